// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types and helpers for the round-robin memory arbiter (package arbiter_pkg).
package arbiter_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_e;

   localparam int unsigned PERF_CNT_W = 16;

   function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
      return (v == {PERF_CNT_W{1'b1}}) ? v : v + PERF_CNT_W'(1);
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational winner picker (module rr_picker): round-robin from a pointer, or lowest index first.
module rr_picker
   import arbiter_pkg::*;
#(
   parameter int N  = 8,
   parameter int IW = 3
)(
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] pointer_i,
   input  arb_mode_e     mode_i,
   input  logic [N-1:0]  exclude_i,
   output logic [IW-1:0] winner_o,
   output logic          valid_o
);

   logic [N-1:0]  masked_s;
   logic [IW-1:0] start_s;

   // Fixed priority ignores both the pointer and the exclusion, so a low-index client can starve others.
   assign masked_s = (mode_i == ARB_FIXED) ? req_i : (req_i & ~exclude_i);
   assign start_s  = (mode_i == ARB_FIXED) ? '0 : pointer_i;

   // Scan from farthest to nearest offset so the nearest requester is written last.
   always_comb begin
      logic [IW-1:0] idx;
      idx      = '0;
      winner_o = '0;
      valid_o  = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         idx      = IW'((int'(start_s) + k) % N);
         winner_o = masked_s[idx] ? idx : winner_o;
         valid_o  = valid_o | masked_s[idx];
      end
   end

endmodule

// File: rtl/mem_arbiter_rr.sv
// NUM_CLIENTS-way memory arbiter with independent read and write grant channels.
// Optional per-client completion counters are enabled with macro ARB_PERF_COUNTERS_EN.
module mem_arbiter_rr
   import arbiter_pkg::*;
#(
   parameter int NUM_CLIENTS           = 8,
   parameter int ADDR_SIZE             = 16,
   parameter int WRITE_DATA_SIZE       = 32,
   parameter int READ_DATA_SIZE        = 512,
   parameter int HAVE_UPSTREAM_ARBITER = 1,
   parameter int ARB_MODE              = 0
)(
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [NUM_CLIENTS-1:0]                      client_read_en,
   input  logic [NUM_CLIENTS-1:0][ADDR_SIZE-1:0]       client_read_addr,
   input  logic [NUM_CLIENTS-1:0]                      client_write_en,
   input  logic [NUM_CLIENTS-1:0][ADDR_SIZE-1:0]       client_write_addr,
   input  logic [NUM_CLIENTS-1:0][WRITE_DATA_SIZE-1:0] client_write_data,
   output logic [READ_DATA_SIZE-1:0]                   client_read_data,
   output logic [NUM_CLIENTS-1:0]                      client_read_valid,
   output logic [NUM_CLIENTS-1:0]                      client_write_done,
   output logic                                        mem_read_en,
   output logic [ADDR_SIZE-1:0]                        mem_read_addr,
   input  logic [READ_DATA_SIZE-1:0]                   mem_read_data,
   output logic                                        mem_write_en,
   output logic [ADDR_SIZE-1:0]                        mem_write_addr,
   output logic [WRITE_DATA_SIZE-1:0]                  mem_write_data,
   input  logic                                        upstream_read_valid,
   input  logic                                        upstream_write_done
`ifdef ARB_PERF_COUNTERS_EN
   ,
   output logic [NUM_CLIENTS-1:0][PERF_CNT_W-1:0]      perf_read_grants,
   output logic [NUM_CLIENTS-1:0][PERF_CNT_W-1:0]      perf_write_grants
`endif
);

   localparam int        IW        = (NUM_CLIENTS > 2) ? $clog2(NUM_CLIENTS) : 1;
   localparam arb_mode_e MODE      = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;
   localparam logic      CMPL_FREE = (HAVE_UPSTREAM_ARBITER == 0);

   // Channel 0 is read, channel 1 is write; both run the same grant machine.
   logic [1:0][NUM_CLIENTS-1:0]                ch_req_s;
   logic [1:0][NUM_CLIENTS-1:0][ADDR_SIZE-1:0] ch_addr_s;
   logic [1:0][NUM_CLIENTS-1:0]                ch_done_s;
   logic [1:0]                                 ch_cmpl_s;
   logic [1:0]                                 ch_busy_s;
   logic [1:0]                                 ch_mem_en_s;
   logic [1:0][ADDR_SIZE-1:0]                  ch_mem_addr_s;
   logic [1:0][IW-1:0]                         ch_grant_s;

   assign ch_req_s[0]  = client_read_en;
   assign ch_req_s[1]  = client_write_en;
   assign ch_addr_s[0] = client_read_addr;
   assign ch_addr_s[1] = client_write_addr;
   assign ch_cmpl_s[0] = CMPL_FREE ? 1'b1 : upstream_read_valid;
   assign ch_cmpl_s[1] = CMPL_FREE ? 1'b1 : upstream_write_done;

   for (genvar c = 0; c < 2; c++) begin : g_ch
      arb_state_e             state_q, state_d;
      logic [IW-1:0]          grant_q, grant_d;
      logic [IW-1:0]          ptr_q, ptr_d;
      logic [IW-1:0]          ptr_inc_s, pick_ptr_s, win_s;
      logic [NUM_CLIENTS-1:0] one_s, excl_s;
      logic                   win_valid_s, cmpl_s, busy_s;

      assign busy_s     = (state_q == ARB_BUSY);
      assign cmpl_s     = busy_s & ch_cmpl_s[c];
      assign one_s      = {{(NUM_CLIENTS-1){1'b0}}, 1'b1};
      assign ptr_inc_s  = (grant_q == IW'(NUM_CLIENTS - 1)) ? '0 : grant_q + IW'(1);
      // On completion the next pick already uses the advanced pointer and skips the finished client.
      assign pick_ptr_s = cmpl_s ? ptr_inc_s : ptr_q;
      assign excl_s     = cmpl_s ? (one_s << grant_q) : '0;

      rr_picker #(
         .N  (NUM_CLIENTS),
         .IW (IW)
      ) u_picker (
         .req_i     (ch_req_s[c]),
         .pointer_i (pick_ptr_s),
         .mode_i    (MODE),
         .exclude_i (excl_s),
         .winner_o  (win_s),
         .valid_o   (win_valid_s)
      );

      // Grant state machine: next state, next grant and next pointer.
      always_comb begin
         state_d = state_q;
         grant_d = grant_q;
         ptr_d   = ptr_q;
         case (state_q)
            ARB_IDLE: begin
               if (win_valid_s) begin
                  grant_d = win_s;
                  state_d = ARB_BUSY;
               end else begin
                  state_d = ARB_IDLE;
               end
            end
            ARB_BUSY: begin
               if (cmpl_s) begin
                  ptr_d = ptr_inc_s;
                  if (win_valid_s) begin
                     grant_d = win_s;
                  end else if (ch_req_s[c][grant_q]) begin
                     grant_d = grant_q;
                  end else begin
                     state_d = ARB_IDLE;
                  end
               end else if (!ch_req_s[c][grant_q]) begin
                  state_d = ARB_IDLE;
               end else begin
                  state_d = ARB_BUSY;
               end
            end
            default: state_d = ARB_IDLE;
         endcase
      end

      // State, grant and pointer registers.
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
         end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
         end
      end

      assign ch_busy_s[c]     = busy_s;
      assign ch_grant_s[c]    = grant_q;
      assign ch_mem_en_s[c]   = busy_s & ch_req_s[c][grant_q];
      assign ch_mem_addr_s[c] = busy_s ? ch_addr_s[c][grant_q] : '0;
      assign ch_done_s[c]     = cmpl_s ? (one_s << grant_q) : '0;
   end

   assign mem_read_en       = ch_mem_en_s[0];
   assign mem_read_addr     = ch_mem_addr_s[0];
   assign client_read_data  = ch_busy_s[0] ? mem_read_data : '0;
   assign client_read_valid = ch_done_s[0];
   assign mem_write_en      = ch_mem_en_s[1];
   assign mem_write_addr    = ch_mem_addr_s[1];
   assign mem_write_data    = ch_busy_s[1] ? client_write_data[ch_grant_s[1]] : '0;
   assign client_write_done = ch_done_s[1];

`ifdef ARB_PERF_COUNTERS_EN
   logic [1:0][NUM_CLIENTS-1:0][PERF_CNT_W-1:0] perf_q;

   // Saturating per-client completion counters for each channel.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_q <= '0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
               if (ch_done_s[c][i]) begin
                  perf_q[c][i] <= sat_inc(perf_q[c][i]);
               end
            end
         end
      end
   end

   assign perf_read_grants  = perf_q[0];
   assign perf_write_grants = perf_q[1];
`else
   // Counters are absent in this build.
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter driven in parallel against a reference model.
module tb_mem_arbiter_rr;
   localparam int N  = 8;
   localparam int AW = 16;
   localparam int WW = 32;
   localparam int RW = 512;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst;
   logic [N-1:0]           rd_en, wr_en;
   logic [N-1:0][AW-1:0]   rd_addr, wr_addr;
   logic [N-1:0][WW-1:0]   wr_data;
   logic                   up_rv, up_wd;

   logic [RW-1:0] c_rdata  [2];
   logic [RW-1:0] m_rdata  [2];
   logic [N-1:0]  c_rvalid [2];
   logic [N-1:0]  c_wdone  [2];
   logic          m_ren    [2];
   logic          m_wen    [2];
   logic [AW-1:0] m_raddr  [2];
   logic [AW-1:0] m_waddr  [2];
   logic [WW-1:0] m_wdata  [2];
`ifdef ARB_PERF_COUNTERS_EN
   logic [N-1:0][15:0] perf_r [2];
   logic [N-1:0][15:0] perf_w [2];
`endif

   function automatic logic [RW-1:0] memdata(input logic [AW-1:0] a);
      return {16{a, ~a}};
   endfunction

   assign m_rdata[0] = memdata(m_raddr[0]);
   assign m_rdata[1] = memdata(m_raddr[1]);

   mem_arbiter_rr #(.ARB_MODE(0)) dut_rr (
      .clk(clk), .rst(rst),
      .client_read_en(rd_en), .client_read_addr(rd_addr),
      .client_write_en(wr_en), .client_write_addr(wr_addr), .client_write_data(wr_data),
      .client_read_data(c_rdata[0]), .client_read_valid(c_rvalid[0]), .client_write_done(c_wdone[0]),
      .mem_read_en(m_ren[0]), .mem_read_addr(m_raddr[0]), .mem_read_data(m_rdata[0]),
      .mem_write_en(m_wen[0]), .mem_write_addr(m_waddr[0]), .mem_write_data(m_wdata[0]),
      .upstream_read_valid(up_rv), .upstream_write_done(up_wd)
`ifdef ARB_PERF_COUNTERS_EN
      , .perf_read_grants(perf_r[0]), .perf_write_grants(perf_w[0])
`endif
   );

   mem_arbiter_rr #(.ARB_MODE(1)) dut_fp (
      .clk(clk), .rst(rst),
      .client_read_en(rd_en), .client_read_addr(rd_addr),
      .client_write_en(wr_en), .client_write_addr(wr_addr), .client_write_data(wr_data),
      .client_read_data(c_rdata[1]), .client_read_valid(c_rvalid[1]), .client_write_done(c_wdone[1]),
      .mem_read_en(m_ren[1]), .mem_read_addr(m_raddr[1]), .mem_read_data(m_rdata[1]),
      .mem_write_en(m_wen[1]), .mem_write_addr(m_waddr[1]), .mem_write_data(m_wdata[1]),
      .upstream_read_valid(up_rv), .upstream_write_done(up_wd)
`ifdef ARB_PERF_COUNTERS_EN
      , .perf_read_grants(perf_r[1]), .perf_write_grants(perf_w[1])
`endif
   );

   // Reference model, indexed [dut][channel]; dut 0 is round-robin, dut 1 fixed priority.
   int            m_busy [2][2];
   int            m_g    [2][2];
   int            m_ptr  [2][2];
   int            m_perf [2][2][N];
   logic [WW-1:0] mem_w  [logic [AW-1:0]];
   int            checks = 0;
   int            errors = 0;

   task automatic check_eq(input string tag, input int idx, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0h expected %0h", tag, idx, obs, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] req, input int start, input int skip, input int fixed);
      if (fixed != 0) begin
         for (int i = 0; i < N; i++) if (req[i]) return i;
         return -1;
      end
      for (int k = 0; k < N; k++) begin
         int i;
         i = (start + k) % N;
         if (req[i] && i != skip) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 2; c++) begin
            m_busy[d][c] = 0; m_g[d][c] = 0; m_ptr[d][c] = 0;
            for (int i = 0; i < N; i++) m_perf[d][c][i] = 0;
         end
   endtask

   // One clock: compare every output against the model, then advance the model across the edge.
   task automatic step();
      logic [N-1:0]  en;
      logic          cmp;
      int            g, b, w, ix;
      logic [AW-1:0] ea;
      #1;
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 2; c++) begin
            en = (c == 0) ? rd_en : wr_en;
            cmp = (c == 0) ? up_rv : up_wd;
            g = m_g[d][c]; b = m_busy[d][c]; ix = d * 2 + c;
            ea = (b != 0) ? ((c == 0) ? rd_addr[g] : wr_addr[g]) : '0;
            if (c == 0) begin
               check_eq("mem_read_en", ix, RW'(m_ren[d]), RW'((b != 0) && en[g]));
               check_eq("mem_read_addr", ix, RW'(m_raddr[d]), RW'(ea));
               check_eq("client_read_valid", ix, RW'(c_rvalid[d]), ((b != 0) && cmp) ? (RW'(1) << g) : RW'(0));
               check_eq("client_read_data", ix, c_rdata[d], (b != 0) ? memdata(ea) : RW'(0));
            end else begin
               check_eq("mem_write_en", ix, RW'(m_wen[d]), RW'((b != 0) && en[g]));
               check_eq("mem_write_addr", ix, RW'(m_waddr[d]), RW'(ea));
               check_eq("client_write_done", ix, RW'(c_wdone[d]), ((b != 0) && cmp) ? (RW'(1) << g) : RW'(0));
               check_eq("mem_write_data", ix, RW'(m_wdata[d]), (b != 0) ? RW'(wr_data[g]) : RW'(0));
            end
`ifdef ARB_PERF_COUNTERS_EN
            for (int i = 0; i < N; i++)
               check_eq("perf", ix * N + i, (c == 0) ? RW'(perf_r[d][i]) : RW'(perf_w[d][i]), RW'(m_perf[d][c][i]));
`endif
         end
      end
      if (m_wen[0] && up_wd) mem_w[m_waddr[0]] = m_wdata[0];
      if (rst) begin
         model_reset();
      end else begin
         for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
               en = (c == 0) ? rd_en : wr_en;
               cmp = (c == 0) ? up_rv : up_wd;
               g = m_g[d][c];
               if (m_busy[d][c] == 0) begin
                  w = pick(en, m_ptr[d][c], -1, d);
                  if (w >= 0) begin m_busy[d][c] = 1; m_g[d][c] = w; end
               end else if (cmp) begin
                  if (m_perf[d][c][g] < 65535) m_perf[d][c][g]++;
                  m_ptr[d][c] = (g + 1) % N;
                  w = pick(en, m_ptr[d][c], g, d);
                  if (w >= 0) m_g[d][c] = w;
                  else if (!en[g]) m_busy[d][c] = 0;
               end else if (!en[g]) begin
                  m_busy[d][c] = 0;
               end
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; rd_en = '0; wr_en = '0; up_rv = 1'b0; up_wd = 1'b0;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int pulses;
      rst = 1'b1; rd_en = '0; wr_en = '0; up_rv = 1'b0; up_wd = 1'b0;
      for (int i = 0; i < N; i++) begin
         rd_addr[i] = AW'(i * 256); wr_addr[i] = AW'(i * 16); wr_data[i] = WW'(i * 7);
      end
      model_reset();
      @(negedge clk);
      step(); step();
      rst = 1'b0;
      step();

      // Single read completing in the third BUSY cycle.
      rd_en = 8'h01; rd_addr[0] = 16'h7A34;
      step(); step(); step();
      up_rv = 1'b1; rd_en = 8'h00;
      #1;
      check_eq("single_valid", 0, RW'(c_rvalid[0]), RW'(8'h01));
      check_eq("single_data", 0, c_rdata[0], memdata(16'h7A34));
      step();
      up_rv = 1'b0;
      #1;
      check_eq("single_idle", 0, RW'(m_ren[0]), RW'(1'b0));
      step();

      // Round-robin rotation with no idle gap; fixed priority keeps client 0.
      do_reset();
      for (int i = 0; i < N; i++) rd_addr[i] = AW'(i * 256);
      rd_en = 8'h07; up_rv = 1'b1;
      step();
      for (int k = 0; k < 6; k++) begin
         #1;
         check_eq("rr_seq", k, RW'(c_rvalid[0]), RW'(8'h01) << (k % 3));
         check_eq("fp_seq", k, RW'(c_rvalid[1]), RW'(8'h01));
         step();
      end

      // Pointer wrap: finish client 6 so the pointer sits at 7, then 7 and 1 request.
      do_reset();
      rd_en = 8'h40; step();
      up_rv = 1'b1; rd_en = 8'h00; step();
      up_rv = 1'b0; rd_en = 8'h82; step();
      up_rv = 1'b1;
      #1; check_eq("wrap_first", 0, RW'(c_rvalid[0]), RW'(8'h80));
      step();
      #1; check_eq("wrap_second", 0, RW'(c_rvalid[0]), RW'(8'h02));
      step();

      // Fixed priority starves client 5 while client 1 keeps requesting.
      do_reset();
      rd_en = 8'h22; up_rv = 1'b1;
      step();
      for (int k = 0; k < 5; k++) begin
         #1; check_eq("fp_starve", k, RW'(c_rvalid[1]), RW'(8'h02));
         step();
      end

      // Parallel read and write in the same cycle.
      do_reset();
      rd_en = 8'h08; rd_addr[3] = 16'h83DB;
      wr_en = 8'h01; wr_addr[0] = 16'h03AF; wr_data[0] = 32'h6AFF;
      step();
      #1; check_eq("par_strobes", 0, RW'({m_ren[0], m_wen[0]}), RW'(2'b11));
      up_wd = 1'b1; up_rv = 1'b1; pulses = 0;
      for (int k = 0; k < 4; k++) begin
         #1; pulses += int'(c_wdone[0][0]);
         step();
         up_wd = 1'b0; up_rv = 1'b0; wr_en = 8'h00; rd_en = 8'h00;
      end
      check_eq("par_done_pulses", 0, RW'(pulses), RW'(1));
      check_eq("par_mem", 0, RW'(mem_w.exists(16'h03AF) ? mem_w[16'h03AF] : 32'h0), RW'(32'h6AFF));

      // Abort: client 2 drops before completion; pointer must stay at 0.
      do_reset();
      rd_en = 8'h04; step(); step();
      rd_en = 8'h00;
      #1; check_eq("abort_novalid", 0, RW'(c_rvalid[0]), RW'(8'h00));
      step();
      #1; check_eq("abort_idle", 0, RW'(m_ren[0]), RW'(1'b0));
      rd_en = 8'h42; step();
      #1; check_eq("abort_ptr", 0, RW'(m_raddr[0]), RW'(rd_addr[1]));
      step();

      // Reset while both channels are BUSY.
      do_reset();
      rd_en = 8'h10; wr_en = 8'h20; step(); step();
      rst = 1'b1; step();
      rst = 1'b0; rd_en = 8'h00; wr_en = 8'h00;
      #1;
      check_eq("rst_outs", 0, RW'({m_ren[0], m_wen[0], m_raddr[0], m_waddr[0], m_wdata[0], c_rvalid[0], c_wdone[0]}), RW'(0));
      check_eq("rst_rdata", 0, c_rdata[0], RW'(0));
      step();

      // Randomized traffic including occasional resets.
      for (int k = 0; k < 3000; k++) begin
         rst   = ($urandom_range(0, 99) == 0);
         rd_en = N'($urandom & $urandom);
         wr_en = N'($urandom & $urandom);
         up_rv = ($urandom_range(0, 2) != 0);
         up_wd = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < N; i++) begin
               rd_addr[i] = AW'($urandom); wr_addr[i] = AW'($urandom); wr_data[i] = WW'($urandom);
            end
         end
         step();
      end

`ifdef ARB_PERF_COUNTERS_EN
      // Counter saturation on client 4.
      do_reset();
      rd_en = 8'h10; up_rv = 1'b1;
      for (int k = 0; k < 70001; k++) step();
      #1; check_eq("perf_sat", 4, RW'(perf_r[0][4]), RW'(16'hFFFF));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
